// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: owns the MENU/CLEAR/INIT/PLAY/PAUSE/OVER state machine,
// the clear-screen sweep, the movement step timer, the reversal-filtered
// direction and the saturating score.
module snake_game_ctrl #(
   parameter int unsigned STEP_CYCLES = 32'd2520000,
   parameter int unsigned SPEEDUP     = 32'd126000,
   parameter int unsigned MIN_STEP    = 32'd630000,
   parameter int unsigned SCREEN_W    = 32'd160,
   parameter int unsigned SCREEN_H    = 32'd120
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       pause_btn,
   input  logic [4:0] dir_req,
   input  logic       ate,
   input  logic       collide,
   output logic       inmenu,
   output logic       ingame,
   output logic       step,
   output logic [1:0] dir,
   output logic [7:0] clr_x,
   output logic [6:0] clr_y,
   output logic       clr_we,
   output logic [7:0] score,
   output logic       game_over,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_MENU  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_INIT  = 3'd2,
      ST_PLAY  = 3'd3,
      ST_PAUSE = 3'd4,
      ST_OVER  = 3'd5
   } state_e;

   localparam logic [7:0]  X_LAST   = 8'(SCREEN_W - 32'd1);
   localparam logic [6:0]  Y_LAST   = 7'(SCREEN_H - 32'd1);
   localparam logic [31:0] HEADROOM = 32'(STEP_CYCLES - MIN_STEP);
   // Period at score 0; the max() guards a configuration with STEP_CYCLES < MIN_STEP.
   localparam logic [31:0] PERIOD0  = (STEP_CYCLES > MIN_STEP) ? 32'(STEP_CYCLES) : 32'(MIN_STEP);

   state_e      state_q;
   logic        start_low_q;   // start has been seen low since reset: arms the edge detector
   logic [31:0] timer_q;
   logic [1:0]  dir_q;
   logic [1:0]  pend_q;
   logic [7:0]  x_q;
   logic [6:0]  y_q;
   logic        we_q;
   logic        step_q;
   logic [7:0]  score_q;

   logic        start_rise_d;
   logic        req_valid_d;
   logic [1:0]  req_code_d;
   logic        req_ok_d;
   logic [31:0] speed_cut_d;
   logic [31:0] period_d;

   // Start edge detect and one-hot direction decode with reversal rejection.
   always_comb begin
      start_rise_d = start & start_low_q;
      req_valid_d  = 1'b1;
      req_code_d   = 2'b00;
      case (dir_req)
         5'b00010: req_code_d = 2'b00;
         5'b00100: req_code_d = 2'b01;
         5'b01000: req_code_d = 2'b10;
         5'b10000: req_code_d = 2'b11;
         default:  req_valid_d = 1'b0;
      endcase
      // Opposite directions differ only in the upper code bit.
      req_ok_d = req_valid_d && (req_code_d != (dir_q ^ 2'b10));
   end

   // Step period for the current score, clamped at MIN_STEP without underflow.
   always_comb begin
      speed_cut_d = 32'(score_q) * 32'(SPEEDUP);
      if (speed_cut_d >= HEADROOM) begin
         period_d = 32'(MIN_STEP);
      end else begin
         period_d = 32'(STEP_CYCLES) - speed_cut_d;
      end
   end

   // Game state machine with its registered sweep, timer, direction and score.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_MENU;
         start_low_q <= 1'b0;
         timer_q     <= 32'd0;
         dir_q       <= 2'b11;
         pend_q      <= 2'b11;
         x_q         <= 8'd0;
         y_q         <= 7'd0;
         we_q        <= 1'b0;
         step_q      <= 1'b0;
         score_q     <= 8'd0;
      end else begin
         start_low_q <= ~start;
         step_q      <= 1'b0;
         case (state_q)
            ST_MENU: begin
               if (start_rise_d) begin
                  state_q <= ST_CLEAR;
                  x_q     <= 8'd0;
                  y_q     <= 7'd0;
                  we_q    <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (x_q == X_LAST) begin
                  x_q <= 8'd0;
                  if (y_q == Y_LAST) begin
                     y_q     <= 7'd0;
                     we_q    <= 1'b0;
                     state_q <= ST_INIT;
                  end else begin
                     y_q <= y_q + 7'd1;
                  end
               end else begin
                  x_q <= x_q + 8'd1;
               end
            end
            ST_INIT: begin
               score_q <= 8'd0;
               dir_q   <= 2'b11;
               pend_q  <= 2'b11;
               timer_q <= PERIOD0;
               state_q <= ST_PLAY;
            end
            ST_PLAY: begin
               if (req_ok_d) begin
                  pend_q <= req_code_d;
               end
               // A due step always fires, even on the cycle that pauses or ends the game.
               if (timer_q == 32'd0) begin
                  step_q  <= 1'b1;
                  dir_q   <= pend_q;
                  timer_q <= period_d;
               end else if (pause_btn && !collide) begin
                  // Pausing freezes the timer on the pause cycle itself.
                  timer_q <= timer_q;
               end else begin
                  timer_q <= timer_q - 32'd1;
               end
               if (collide) begin
                  state_q <= ST_OVER;
               end else begin
                  if (ate && (score_q != 8'd255)) begin
                     score_q <= score_q + 8'd1;
                  end
                  if (pause_btn) begin
                     state_q <= ST_PAUSE;
                  end
               end
            end
            ST_PAUSE: begin
               if (pause_btn) begin
                  state_q <= ST_PLAY;
               end
            end
            ST_OVER: begin
               if (start_rise_d) begin
                  state_q <= ST_CLEAR;
                  x_q     <= 8'd0;
                  y_q     <= 7'd0;
                  we_q    <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_MENU;
               we_q    <= 1'b0;
            end
         endcase
      end
   end

   assign inmenu    = (state_q == ST_MENU) || (state_q == ST_CLEAR) || (state_q == ST_INIT);
   assign ingame    = (state_q == ST_PLAY) || (state_q == ST_PAUSE);
   assign game_over = (state_q == ST_OVER);
   assign step      = step_q;
   assign dir       = dir_q;
   assign clr_x     = x_q;
   assign clr_y     = y_q;
   assign clr_we    = we_q;
   assign score     = score_q;
   assign state     = state_q;

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Top-level game sequencer for the snake datapath.
- Owns the game state machine: MENU, CLEAR, INIT, PLAY, PAUSE, OVER.
- Drives the datapath's inmenu/ingame controls and a clear-screen pixel sweep toward the VGA adapter.
- Produces the movement step pulse, the reversal-filtered direction, and the score, replacing the free-running frame/delay counters.

Parameters:
- STEP_CYCLES, 2520000: clock cycles between step pulses at score 0.
- SPEEDUP, 126000: cycles removed from the step period per point scored.
- MIN_STEP, 630000: floor on the step period.
- SCREEN_W, 160: sweep width in pixels.
- SCREEN_H, 120: sweep height in pixels.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- resetn  in  1  asynchronous active-low reset
- start  in  1  level input (switch), rising edge detected internally
- pause_btn  in  1  single-cycle pulse that toggles pause
- dir_req  in  5  one-hot request: 00010 up, 00100 left, 01000 down, 10000 right
- ate  in  1  single-cycle pulse from datapath: head hit apple
- collide  in  1  single-cycle pulse from datapath: head hit body or wall
- inmenu  out  1  datapath reset/hold
- ingame  out  1  datapath active
- step  out  1  single-cycle move strobe
- dir  out  2  committed direction: 00 up, 01 left, 10 down, 11 right
- clr_x  out  8  sweep x coordinate
- clr_y  out  7  sweep y coordinate
- clr_we  out  1  sweep write enable; colour is black
- score  out  8  apples eaten, saturating
- game_over  out  1  high in OVER
- state  out  3  MENU=0, CLEAR=1, INIT=2, PLAY=3, PAUSE=4, OVER=5

Behaviour:
- Reset (asynchronous, resetn=0) sets: state MENU, score 0, dir 11, pending dir 11, sweep x/y 0, step timer 0, start edge register 0, all strobes 0.
- Reset mid-sweep or mid-game aborts immediately to MENU.
- Outputs are registered, except inmenu, ingame and game_over, which decode combinationally from state.
  - inmenu = 1 in MENU, CLEAR, INIT.
  - ingame = 1 in PLAY, PAUSE.
  - game_over = 1 in OVER.
- MENU: start rising edge -> CLEAR. The start rising edge is ignored in every state except MENU and OVER.
- CLEAR:
  - clr_we = 1 every cycle.
  - clr_x increments 0..SCREEN_W-1, then wraps to 0 and increments clr_y.
  - On the cycle that writes (SCREEN_W-1, SCREEN_H-1), the next state is INIT.
  - Total is exactly SCREEN_W*SCREEN_H write cycles; x/y return to 0 on exit.
- INIT (1 cycle):
  - score <- 0; dir and pending <- 11 (right).
  - Step timer loads the period computed with score 0.
  - Next state PLAY.
- PLAY:
  - Timer decrements each cycle.
  - When the timer is 0: step = 1 for that cycle, dir <- pending, and the timer reloads period = max(MIN_STEP, STEP_CYCLES - score*SPEEDUP).
  - The period is computed in 32-bit unsigned with no underflow: if score*SPEEDUP >= STEP_CYCLES - MIN_STEP, use MIN_STEP.
  - The score used is the value registered at reload.
- Direction filter:
  - A dir_req that is exactly one-hot updates pending, unless it is the reverse of the committed dir (up/down, left/right).
  - Zero or multi-hot requests are ignored.
  - Several requests between steps: the last legal one wins. Reversal is checked against committed dir, not pending.
  - Requests are accepted in PLAY only.
- ate in PLAY: score increments, saturating at 255.
- collide in PLAY: next state OVER; score frozen.
- ate and collide in the same cycle: collide wins and score is not incremented.
- collide on a step cycle: the step pulse is still emitted, then OVER.
- pause_btn in PLAY -> PAUSE.
  - In PAUSE: timer holds; step = 0; ate, collide and dir_req are ignored.
  - pause_btn in PAUSE -> PLAY; the timer resumes from its held value.
  - pause_btn is ignored elsewhere.
  - pause_btn and collide in the same PLAY cycle: collide wins.
- OVER: all strobes 0; score held. start rising edge -> CLEAR, which leads to a new game.
- start held high through reset does not trigger a game; a fresh 0->1 is required.

Test Plan:
Run with STEP_CYCLES=10, SPEEDUP=2, MIN_STEP=4, SCREEN_W=4, SCREEN_H=3.
1. Reset, then start 0->1 -> CLEAR for exactly 12 cycles with (x,y) sequence (0,0),(1,0)..(3,2), clr_we=1; then INIT for 1 cycle; then PLAY with inmenu=0, ingame=1.
2. In PLAY with no input -> step pulses every 11 cycles (10 countdown + reload); dir=11 throughout.
3. dir_req=00100 (left, reverse of right) -> ignored. dir_req=00010 then 01000 before the next step -> dir=10 (down) after that step.
4. Five ate pulses -> score=5; period clamps to MIN_STEP=4 (10-10 <= 4), so step spacing becomes 5 cycles. 260 ate pulses -> score=255.
5. pause_btn at timer=6 -> no step for 50 cycles, ate ignored. pause_btn again -> step 7 cycles later.
6. ate and collide in the same cycle at score=3 -> OVER, score stays 3, game_over=1. resetn low during a later CLEAR -> MENU immediately; start held high -> no restart until it toggles.
